// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0 side bundle for the exception sequencer: MEM-stage flags and CP0 state in,
// kill/flush/redirect and CP0 capture fields out.
interface exc_ctrl_if;
  logic        mem_valid;
  logic        mem_stall;
  logic [31:0] mem_pc;
  logic        mem_delayslot;
  logic [7:0]  mem_exc;
  logic [31:0] mem_addr;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        mem_kill;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_badaddr;
  logic [31:0] cp0_pc;
  logic        cp0_delayslot;
  logic        cp0_wr_inhibit;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output mem_valid, mem_stall, mem_pc, mem_delayslot, mem_exc, mem_addr,
           cp0_status, cp0_cause, cp0_epc,
    input  mem_kill, cp0_exccode, cp0_badaddr, cp0_pc, cp0_delayslot,
           cp0_wr_inhibit, flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  mem_valid, mem_stall, mem_pc, mem_delayslot, mem_exc, mem_addr,
           cp0_status, cp0_cause, cp0_epc,
    output mem_kill, cp0_exccode, cp0_badaddr, cp0_pc, cp0_delayslot,
           cp0_wr_inhibit, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt sequencer: picks the highest-priority event, kills the
// instruction, presents it to CP0 for one cycle, flushes, then redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [4:0]  NONE_CODE  = 5'h1F
) (
  input  logic        clk,
  input  logic        rst,
  exc_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0]  state_r;
  logic [4:0]  code_r;
  logic [31:0] badaddr_r;
  logic [31:0] pc_r;
  logic        ds_r;
  logic        eret_r;

  logic        int_pend_s;
  logic        capture_s;
  logic [4:0]  code_s;
  logic [31:0] badaddr_s;
  logic        eret_s;
  logic        unused_s;

  // Bits of Status/Cause that play no part in the interrupt test.
  assign unused_s = ^{bus.cp0_status[31:16], bus.cp0_status[7:2],
                      bus.cp0_cause[31:16], bus.cp0_cause[7:0]};

  // Interrupt test, capture qualification and priority pick of the winning event.
  always_comb begin
    int_pend_s = bus.cp0_status[0] & ~bus.cp0_status[1] &
                 (|(bus.cp0_status[15:8] & bus.cp0_cause[15:8]));
    capture_s  = (state_r == ST_IDLE) & bus.mem_valid & ~bus.mem_stall &
                 (int_pend_s | (|bus.mem_exc));
    code_s     = NONE_CODE;
    badaddr_s  = 32'h0000_0000;
    eret_s     = 1'b0;
    if (int_pend_s) begin
      code_s = 5'h00;
    end else if (bus.mem_exc[0]) begin
      code_s    = 5'h04;
      badaddr_s = bus.mem_pc;
    end else if (bus.mem_exc[1]) begin
      code_s = 5'h0A;
    end else if (bus.mem_exc[2]) begin
      code_s = 5'h08;
    end else if (bus.mem_exc[3]) begin
      code_s = 5'h09;
    end else if (bus.mem_exc[4]) begin
      code_s = 5'h0C;
    end else if (bus.mem_exc[5]) begin
      code_s    = 5'h04;
      badaddr_s = bus.mem_addr;
    end else if (bus.mem_exc[6]) begin
      code_s    = 5'h05;
      badaddr_s = bus.mem_addr;
    end else if (bus.mem_exc[7]) begin
      code_s = 5'h0E;
      eret_s = 1'b1;
    end else begin
      code_s = NONE_CODE;
    end
  end

  // Sequencer state and the event fields held across FLUSH/REDIRECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      code_r    <= NONE_CODE;
      badaddr_r <= 32'h0000_0000;
      pc_r      <= 32'h0000_0000;
      ds_r      <= 1'b0;
      eret_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            state_r   <= ST_FLUSH;
            code_r    <= code_s;
            badaddr_r <= badaddr_s;
            pc_r      <= bus.mem_pc;
            ds_r      <= bus.mem_delayslot;
            eret_r    <= eret_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH:    state_r <= ST_REDIRECT;
        ST_REDIRECT: state_r <= ST_IDLE;
        default:     state_r <= ST_IDLE;
      endcase
    end
  end

  // Output decode; EPC is read live in REDIRECT so a CP0 update from the FLUSH edge is seen.
  always_comb begin
    bus.mem_kill       = capture_s;
    bus.cp0_exccode    = NONE_CODE;
    bus.cp0_badaddr    = 32'h0000_0000;
    bus.cp0_pc         = 32'h0000_0000;
    bus.cp0_delayslot  = 1'b0;
    bus.cp0_wr_inhibit = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0000_0000;
    bus.busy           = (state_r != ST_IDLE);
    case (state_r)
      ST_FLUSH: begin
        bus.cp0_exccode    = code_r;
        bus.cp0_badaddr    = badaddr_r;
        bus.cp0_pc         = pc_r;
        bus.cp0_delayslot  = ds_r;
        bus.cp0_wr_inhibit = 1'b1;
        bus.flush          = 1'b1;
      end
      ST_REDIRECT: begin
        bus.flush          = 1'b1;
        bus.redirect_valid = 1'b1;
        if (eret_r) begin
          bus.redirect_pc = bus.cp0_epc;
        end else begin
          bus.redirect_pc = EXC_VECTOR;
        end
      end
      default: begin
        bus.flush = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: full capture/flush/redirect sequences with hand-computed values.
module tb_exc_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  exc_ctrl_if bus ();
  exc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic apply(input logic v, input logic st, input logic [31:0] pc, input logic ds,
                       input logic [7:0] exc, input logic [31:0] addr,
                       input logic [31:0] status, input logic [31:0] cause, input logic [31:0] epc);
    bus.mem_valid = v;     bus.mem_stall = st;   bus.mem_pc = pc;
    bus.mem_delayslot = ds; bus.mem_exc = exc;   bus.mem_addr = addr;
    bus.cp0_status = status; bus.cp0_cause = cause; bus.cp0_epc = epc;
  endtask

  task automatic idle_inputs();
    apply(1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Inputs stay held through FLUSH so that a second capture there would be visible.
  task automatic run_seq(input string tag, input logic [4:0] code, input logic [31:0] pc,
                         input logic [31:0] bad, input logic ds, input logic [31:0] rpc);
    check_val({tag, ".kill"}, {31'd0, bus.mem_kill}, 32'd1);
    @(posedge clk); #1;
    check_val({tag, ".f_code"}, {27'd0, bus.cp0_exccode}, {27'd0, code});
    check_val({tag, ".f_pc"}, bus.cp0_pc, pc);
    check_val({tag, ".f_bad"}, bus.cp0_badaddr, bad);
    check_val({tag, ".f_ds"}, {31'd0, bus.cp0_delayslot}, {31'd0, ds});
    check_val({tag, ".f_ctl"}, {28'd0, bus.flush, bus.cp0_wr_inhibit, bus.busy, bus.redirect_valid},
              32'h0000_000E);
    check_val({tag, ".f_kill"}, {31'd0, bus.mem_kill}, 32'd0);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    bus.mem_exc   = 8'h00;
    check_val({tag, ".r_pc"}, bus.redirect_pc, rpc);
    check_val({tag, ".r_ctl"}, {28'd0, bus.flush, bus.cp0_wr_inhibit, bus.busy, bus.redirect_valid},
              32'h0000_000B);
    check_val({tag, ".r_code"}, {27'd0, bus.cp0_exccode}, 32'h0000_001F);
    @(posedge clk); #1;
    check_val({tag, ".i_ctl"}, {28'd0, bus.flush, bus.cp0_wr_inhibit, bus.busy, bus.redirect_valid},
              32'h0000_0000);
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.code", {27'd0, bus.cp0_exccode}, 32'h0000_001F);
    check_val("rst.ctl", {28'd0, bus.flush, bus.cp0_wr_inhibit, bus.busy, bus.redirect_valid}, 32'h0);
    check_val("rst.rpc", bus.redirect_pc, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    apply(1'b1, 1'b0, 32'h8000_0100, 1'b0, 8'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 run_seq("ov", 5'h0C, 32'h8000_0100, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0300, 1'b1, 8'h40, 32'h0000_1003, 32'h0, 32'h0, 32'h0);
    #1 run_seq("ades", 5'h05, 32'h8000_0300, 32'h0000_1003, 1'b1, VEC);

    apply(1'b1, 1'b0, 32'h8000_0500, 1'b0, 8'h02, 32'h0, 32'h0000_0401, 32'h0000_0400, 32'h0);
    #1 run_seq("int_ri", 5'h00, 32'h8000_0500, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0600, 1'b0, 8'h80, 32'h0, 32'h0, 32'h0, 32'h8000_0200);
    #1 run_seq("eret", 5'h0E, 32'h8000_0600, 32'h0, 1'b0, 32'h8000_0200);

    apply(1'b1, 1'b0, 32'h8000_0400, 1'b0, 8'h21, 32'h0000_2000, 32'h0, 32'h0, 32'h0);
    #1 run_seq("fadel_dadel", 5'h04, 32'h8000_0400, 32'h8000_0400, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0700, 1'b0, 8'h06, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 run_seq("ri_sys", 5'h0A, 32'h8000_0700, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0704, 1'b0, 8'h0C, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 run_seq("sys_bp", 5'h08, 32'h8000_0704, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0708, 1'b0, 8'h18, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 run_seq("bp_ov", 5'h09, 32'h8000_0708, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_070C, 1'b1, 8'h60, 32'h0000_3001, 32'h0, 32'h0, 32'h0);
    #1 run_seq("dadel_ades", 5'h04, 32'h8000_070C, 32'h0000_3001, 1'b1, VEC);

    apply(1'b1, 1'b0, 32'h8000_0710, 1'b0, 8'hC0, 32'h0000_4002, 32'h0, 32'h0, 32'h8000_0900);
    #1 run_seq("ades_eret", 5'h05, 32'h8000_0710, 32'h0000_4002, 1'b0, VEC);

    // Interrupt masked by EXL, then by IE=0: neither may capture.
    apply(1'b1, 1'b0, 32'h8000_0800, 1'b0, 8'h00, 32'h0, 32'h0000_0403, 32'h0000_0400, 32'h0);
    #1 check_val("int_exl.kill", {31'd0, bus.mem_kill}, 32'd0);
    bus.cp0_status = 32'h0000_0400;
    #1 check_val("int_ie0.kill", {31'd0, bus.mem_kill}, 32'd0);
    apply(1'b0, 1'b0, 32'h8000_0800, 1'b0, 8'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    #1 check_val("bubble.kill", {31'd0, bus.mem_kill}, 32'd0);

    apply(1'b1, 1'b1, 32'h8000_0A00, 1'b0, 8'h04, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1 check_val("stall.kill", {31'd0, bus.mem_kill}, 32'd0);
      check_val("stall.busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
    end
    bus.mem_stall = 1'b0;
    #1 run_seq("sys_after_stall", 5'h08, 32'h8000_0A00, 32'h0, 1'b0, VEC);

    apply(1'b1, 1'b0, 32'h8000_0B00, 1'b1, 8'h10, 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    check_val("rstmid.pre_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check_val("rstmid.code", {27'd0, bus.cp0_exccode}, 32'h0000_001F);
    check_val("rstmid.ctl", {28'd0, bus.flush, bus.cp0_wr_inhibit, bus.busy, bus.redirect_valid}, 32'h0);
    check_val("rstmid.pc", bus.cp0_pc, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rstmid.after", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
